// File: rtl/carfield_rtc_gen_pkg.sv
// Shared configuration for the Carfield RTC/tick generator.
// The default ratio of 50 gives a 1 MHz RTC from a 50 MHz host clock.
package carfield_pkg;

    localparam int unsigned CarfieldRtcNumChan    = 2;
    localparam int unsigned CarfieldRtcDivWidth   = 16;
    localparam int unsigned CarfieldRtcDefaultDiv = 50;

    // Length of the high phase: ceil(div/2).
    function automatic logic [31:0] rtc_high_len(input logic [31:0] div);
        return div - (div >> 1);
    endfunction

endpackage

// File: rtl/carfield_rtc_gen_chan.sv
// One RTC channel: programmable divider with a square-wave and a tick output.
// Optional forced wrap input when CARFIELD_RTC_GEN_SYNC_EN is defined.
module carfield_rtc_chan
    import carfield_pkg::*;
#(
    parameter int unsigned DivWidth   = CarfieldRtcDivWidth,
    parameter int unsigned DefaultDiv = CarfieldRtcDefaultDiv
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef CARFIELD_RTC_GEN_SYNC_EN
    input  logic                sync,
`endif
    input  logic                div_valid,
    input  logic [DivWidth-1:0] div_new,
    output logic                div_ready,
    output logic                clk_div,
    output logic                tick,
    output logic                active
);

    localparam logic [DivWidth-1:0] ResetDiv = DivWidth'(DefaultDiv);

    logic [DivWidth-1:0] div_q, cnt_q, pend_div_q;
    logic [DivWidth-1:0] cnt_nxt, high;
    logic                pend_q, clk_q, tick_q;
    logic                wrap, accept;

    always_comb begin
        cnt_nxt = cnt_q + DivWidth'(1);
        high    = DivWidth'(rtc_high_len(32'(div_q)));
        accept  = div_valid && !pend_q;
`ifdef CARFIELD_RTC_GEN_SYNC_EN
        wrap    = (cnt_q == div_q - DivWidth'(1)) || sync;
`else
        wrap    = (cnt_q == div_q - DivWidth'(1));
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= ResetDiv;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_div_q <= '0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            // Accept only happens with pend_q low, apply only with it high,
            // so the two never update pend_q on the same edge.
            if (accept) begin
                pend_q     <= 1'b1;
                pend_div_q <= div_new;
            end
            if (div_q != '0) begin
                if (wrap) begin
                    cnt_q  <= '0;
                    tick_q <= 1'b1;
                    clk_q  <= 1'b1;
                    if (pend_q) begin
                        div_q  <= pend_div_q;
                        pend_q <= 1'b0;
                    end
                end else begin
                    cnt_q  <= cnt_nxt;
                    tick_q <= 1'b0;
                    clk_q  <= (cnt_nxt < high);
                end
            end else begin
                cnt_q  <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                if (pend_q) begin
                    div_q  <= pend_div_q;
                    pend_q <= 1'b0;
                end
            end
        end
    end

    assign div_ready = !pend_q;
    assign clk_div   = clk_q;
    assign tick      = tick_q;
    assign active    = (div_q != '0);

endmodule

// File: rtl/carfield_rtc_gen.sv
// Multi-channel RTC/tick generator; NumChan independent carfield_rtc_chan instances.
// Define CARFIELD_RTC_GEN_SYNC_EN to add the sync_i forced-wrap input.
module carfield_rtc_gen
    import carfield_pkg::*;
#(
    parameter int unsigned NumChan    = CarfieldRtcNumChan,
    parameter int unsigned DivWidth   = CarfieldRtcDivWidth,
    parameter int unsigned DefaultDiv = CarfieldRtcDefaultDiv
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
`ifdef CARFIELD_RTC_GEN_SYNC_EN
    input  logic                             sync_i,
`endif
    input  logic [NumChan-1:0]               div_valid_i,
    input  logic [NumChan-1:0][DivWidth-1:0] div_i,
    output logic [NumChan-1:0]               div_ready_o,
    output logic [NumChan-1:0]               clk_o,
    output logic [NumChan-1:0]               tick_o,
    output logic [NumChan-1:0]               active_o
);

    if (64'(DefaultDiv) >= (64'd1 << DivWidth)) begin : g_bad_default
        $error("carfield_rtc_gen: DefaultDiv does not fit in DivWidth bits");
    end

    for (genvar c = 0; c < NumChan; c++) begin : g_chan
        carfield_rtc_chan #(
            .DivWidth   (DivWidth),
            .DefaultDiv (DefaultDiv)
        ) u_chan (
            .clk       (clk_i),
            .rst_n     (rst_ni),
`ifdef CARFIELD_RTC_GEN_SYNC_EN
            .sync      (sync_i),
`endif
            .div_valid (div_valid_i[c]),
            .div_new   (div_i[c]),
            .div_ready (div_ready_o[c]),
            .clk_div   (clk_o[c]),
            .tick      (tick_o[c]),
            .active    (active_o[c])
        );
    end

endmodule

// File: tb/tb_carfield_rtc_gen.sv
// Scoreboard bench for carfield_rtc_gen: directed stimulus queues expected
// per-edge output values; an edge-driven monitor pops and compares them.
module tb_carfield_rtc_gen;

    localparam int NC = 2;
    localparam int DW = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic [NC-1:0]          div_valid = '0;
    logic [NC-1:0][DW-1:0]  div_in = '0;
    logic [NC-1:0]          div_ready, clk_div, tick, active;
`ifdef CARFIELD_RTC_GEN_SYNC_EN
    logic                   sync = 1'b0;
`endif

    always #5 clk = ~clk;

    carfield_rtc_gen #(
        .NumChan    (NC),
        .DivWidth   (DW),
        .DefaultDiv (50)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
`ifdef CARFIELD_RTC_GEN_SYNC_EN
        .sync_i      (sync),
`endif
        .div_valid_i (div_valid),
        .div_i       (div_in),
        .div_ready_o (div_ready),
        .clk_o       (clk_div),
        .tick_o      (tick),
        .active_o    (active)
    );

    localparam int K_TICK = 0, K_CLK = 1, K_READY = 2, K_ACT = 3;

    typedef struct {
        int   at;     // edge index after reset release; -1 = while in reset
        int   ch;
        int   kind;
        logic val;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   edge_n = 0;
    bit   run = 1'b0;

    function automatic void want(input int at, input int ch, input int kind, input logic val);
        exp_t e;
        e.at = at; e.ch = ch; e.kind = kind; e.val = val;
        exp_q.push_back(e);
    endfunction

    function automatic logic actual(input int ch, input int kind);
        case (kind)
            K_TICK:  return tick[ch];
            K_CLK:   return clk_div[ch];
            K_READY: return div_ready[ch];
            default: return active[ch];
        endcase
    endfunction

    function automatic string kname(input int kind);
        case (kind)
            K_TICK:  return "tick";
            K_CLK:   return "clk";
            K_READY: return "ready";
            default: return "active";
        endcase
    endfunction

    // Monitor: samples 1 time unit after each rising edge or reset assertion.
    initial begin
        int   cur;
        int   i;
        logic a;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (rst_n && run) begin
                edge_n++;
                cur = edge_n;
            end else begin
                cur = -1;
            end
            i = 0;
            while (i < exp_q.size()) begin
                if (exp_q[i].at == cur) begin
                    a = actual(exp_q[i].ch, exp_q[i].kind);
                    checks++;
                    if (a !== exp_q[i].val) begin
                        errors++;
                        $display("FAIL %s[%0d] at edge %0d: got %b expected %b",
                                 kname(exp_q[i].kind), exp_q[i].ch, cur, a, exp_q[i].val);
                    end
                    exp_q.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    task automatic wait_edge(input int n);
        int guard = 0;
        while (edge_n < n) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                errors++;
                checks++;
                $display("FAIL wait_edge: got edge %0d expected edge %0d", edge_n, n);
                return;
            end
        end
    endtask

    task automatic do_reset();
        run       = 1'b0;
        rst_n     = 1'b0;
        div_valid = '0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
        run    = 1'b1;
    endtask

    initial begin
        #2;
        // Reset values
        for (int c = 0; c < NC; c++) begin
            want(-1, c, K_CLK, 1'b0);
            want(-1, c, K_TICK, 1'b0);
            want(-1, c, K_READY, 1'b1);
            want(-1, c, K_ACT, 1'b1);
        end
        do_reset();

        // Defaults, no writes
        want(49, 0, K_TICK, 1'b0);  want(50, 0, K_TICK, 1'b1);  want(51, 0, K_TICK, 1'b0);
        want(100, 0, K_TICK, 1'b1); want(150, 0, K_TICK, 1'b1); want(50, 1, K_TICK, 1'b1);
        want(1, 0, K_CLK, 1'b1);    want(24, 0, K_CLK, 1'b1);   want(25, 0, K_CLK, 1'b0);
        want(49, 0, K_CLK, 1'b0);   want(50, 0, K_CLK, 1'b1);   want(74, 0, K_CLK, 1'b1);
        want(75, 0, K_CLK, 1'b0);
        wait_edge(151);

        // Ch0 ratio 4 accepted at edge 10
        do_reset();
        want(9, 0, K_READY, 1'b1);  want(10, 0, K_READY, 1'b0);
        want(49, 0, K_READY, 1'b0); want(50, 0, K_READY, 1'b1);
        want(50, 0, K_TICK, 1'b1);  want(53, 0, K_TICK, 1'b0);
        want(54, 0, K_TICK, 1'b1);  want(58, 0, K_TICK, 1'b1);
        want(50, 0, K_CLK, 1'b1);   want(51, 0, K_CLK, 1'b1);
        want(52, 0, K_CLK, 1'b0);   want(53, 0, K_CLK, 1'b0);   want(54, 0, K_CLK, 1'b1);
        want(50, 1, K_TICK, 1'b1);  want(54, 1, K_TICK, 1'b0);  want(100, 1, K_TICK, 1'b1);
        wait_edge(9);
        div_valid[0] = 1'b1; div_in[0] = 16'd4;
        wait_edge(10);
        div_valid[0] = 1'b0;
        wait_edge(101);

        // Odd ratio 5 on ch0, unit ratio on ch1, both accepted at edge 1
        do_reset();
        want(50, 0, K_TICK, 1'b1);  want(54, 0, K_TICK, 1'b0);
        want(55, 0, K_TICK, 1'b1);  want(60, 0, K_TICK, 1'b1);
        want(51, 0, K_CLK, 1'b1);   want(52, 0, K_CLK, 1'b1);   want(53, 0, K_CLK, 1'b0);
        want(54, 0, K_CLK, 1'b0);   want(55, 0, K_CLK, 1'b1);
        want(49, 1, K_TICK, 1'b0);  want(49, 1, K_CLK, 1'b0);   want(50, 1, K_TICK, 1'b1);
        want(51, 1, K_TICK, 1'b1);  want(52, 1, K_TICK, 1'b1);  want(53, 1, K_TICK, 1'b1);
        want(51, 1, K_CLK, 1'b1);   want(53, 1, K_CLK, 1'b1);
        div_valid = 2'b11; div_in[0] = 16'd5; div_in[1] = 16'd1;
        wait_edge(1);
        div_valid = '0;
        wait_edge(61);

        // Disable ch0 then re-enable with 3; back-to-back writes on ch1
        do_reset();
        want(50, 0, K_TICK, 1'b1);  want(51, 0, K_TICK, 1'b0);
        want(49, 0, K_ACT, 1'b1);   want(50, 0, K_ACT, 1'b0);
        want(61, 0, K_ACT, 1'b0);   want(62, 0, K_ACT, 1'b1);
        want(51, 0, K_CLK, 1'b0);   want(60, 0, K_CLK, 1'b0);   want(62, 0, K_CLK, 1'b0);
        want(63, 0, K_CLK, 1'b1);   want(64, 0, K_CLK, 1'b0);   want(65, 0, K_CLK, 1'b1);
        want(62, 0, K_TICK, 1'b0);  want(65, 0, K_TICK, 1'b1);  want(66, 0, K_TICK, 1'b0);
        want(68, 0, K_TICK, 1'b1);  want(71, 0, K_TICK, 1'b1);
        want(61, 0, K_READY, 1'b0); want(62, 0, K_READY, 1'b1);
        want(60, 1, K_READY, 1'b1); want(61, 1, K_READY, 1'b0); want(99, 1, K_READY, 1'b0);
        want(100, 1, K_READY, 1'b1); want(101, 1, K_READY, 1'b0);
        want(100, 1, K_TICK, 1'b1); want(108, 1, K_TICK, 1'b0); want(109, 1, K_TICK, 1'b1);
        want(118, 1, K_TICK, 1'b0); want(120, 1, K_TICK, 1'b1);
        div_valid[0] = 1'b1; div_in[0] = 16'd0;
        wait_edge(1);
        div_valid[0] = 1'b0;
        wait_edge(60);
        div_valid = 2'b11; div_in[0] = 16'd3; div_in[1] = 16'd9;
        wait_edge(61);
        div_valid[0] = 1'b0; div_in[1] = 16'd11;
        wait_edge(101);
        div_valid[1] = 1'b0;
        wait_edge(121);

        // Async reset mid-period with a pending ratio on ch0
        do_reset();
        want(10, 0, K_CLK, 1'b1);   want(10, 0, K_READY, 1'b0); want(10, 1, K_CLK, 1'b1);
        wait_edge(4);
        div_valid[0] = 1'b1; div_in[0] = 16'd4;
        wait_edge(5);
        div_valid[0] = 1'b0;
        wait_edge(10);
        want(-1, 0, K_CLK, 1'b0);   want(-1, 0, K_TICK, 1'b0);
        want(-1, 0, K_READY, 1'b1); want(-1, 0, K_ACT, 1'b1);   want(-1, 1, K_CLK, 1'b0);
        do_reset();
        want(3, 0, K_CLK, 1'b1);    want(25, 0, K_CLK, 1'b0);   want(5, 0, K_READY, 1'b1);
        want(4, 0, K_TICK, 1'b0);   want(8, 0, K_TICK, 1'b0);
        want(50, 0, K_TICK, 1'b1);  want(54, 0, K_TICK, 1'b0);
        wait_edge(55);

`ifdef CARFIELD_RTC_GEN_SYNC_EN
        // Forced wrap of both channels at edge 81
        do_reset();
        want(81, 0, K_TICK, 1'b1);  want(100, 0, K_TICK, 1'b0);
        want(130, 0, K_TICK, 1'b0); want(131, 0, K_TICK, 1'b1);
        want(81, 1, K_TICK, 1'b1);  want(85, 1, K_TICK, 1'b0);  want(88, 1, K_TICK, 1'b1);
        div_valid[1] = 1'b1; div_in[1] = 16'd7;
        wait_edge(1);
        div_valid[1] = 1'b0;
        wait_edge(80);
        sync = 1'b1;
        wait_edge(81);
        sync = 1'b0;
        wait_edge(132);
`endif

        foreach (exp_q[i]) begin
            errors++;
            checks++;
            $display("FAIL %s[%0d] at edge %0d: got no sample expected %b",
                     kname(exp_q[i].kind), exp_q[i].ch, exp_q[i].at, exp_q[i].val);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
